floor_call_scheduler: RTL

FLOOR_CALL_SCHEDULER -- requirements
Module: floor_call_scheduler

---
 rtl/floor_call_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/floor_call_scheduler.sv
// Single-car floor call scheduler for a 4-floor elevator: latches calls, sweeps up/down
// choosing the nearest pending floor in the travel direction, and times door dwell from a tick strobe.
module floor_call_scheduler #(
    parameter int DWELL_TICKS = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [3:0] i_call_btn,
    input  logic [3:0] i_present_floor,
    output logic [3:0] o_req_floor,
    output logic [3:0] o_pending,
    output logic       o_door_open,
    output logic       o_dir_up,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR
    } state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL_TICKS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_req_floor;
    logic [3:0] w_req_nxt;
    logic [3:0] r_pending;
    logic [3:0] w_pending_nxt;
    logic [3:0] r_dwell;
    logic [3:0] w_dwell_nxt;
    logic       r_door_open;
    logic       w_door_nxt;
    logic       r_dir_up;
    logic       w_dir_nxt;
    logic       r_busy;

    logic       w_valid;
    logic       w_here_call;
    logic [3:0] w_below_mask;
    logic [3:0] w_above_mask;
    logic [3:0] w_pend_above;
    logic [3:0] w_pend_below;
    logic [3:0] w_clr;

    function automatic logic [3:0] lowestBit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic [3:0] highestBit(input logic [3:0] v);
        logic [3:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Masks are only meaningful when the floor report is one-hot; otherwise nothing but pending moves.
    always_comb begin
        w_valid      = (i_present_floor != 4'd0) &&
                       ((i_present_floor & (i_present_floor - 4'd1)) == 4'd0);
        w_below_mask = i_present_floor - 4'd1;
        w_above_mask = ~(i_present_floor | w_below_mask);
        w_pend_above = r_pending & w_above_mask;
        w_pend_below = r_pending & w_below_mask;
        w_here_call  = w_valid && (|(i_call_btn & i_present_floor));

        w_state_nxt = r_state;
        w_req_nxt   = r_req_floor;
        w_dir_nxt   = r_dir_up;
        w_door_nxt  = r_door_open;
        w_dwell_nxt = r_dwell;
        w_clr       = 4'd0;

        if (w_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_here_call || (|(r_pending & i_present_floor))) begin
                        w_state_nxt = DOOR;
                        w_clr       = i_present_floor;
                        w_dwell_nxt = DWELL_LOAD;
                        w_door_nxt  = 1'b1;
                        w_req_nxt   = i_present_floor;
                    end else if (|w_pend_above) begin
                        w_state_nxt = MOVING;
                        w_dir_nxt   = 1'b1;
                        w_req_nxt   = lowestBit(w_pend_above);
                    end else if (|w_pend_below) begin
                        w_state_nxt = MOVING;
                        w_dir_nxt   = 1'b0;
                        w_req_nxt   = highestBit(w_pend_below);
                    end else begin
                        w_req_nxt   = i_present_floor;
                    end
                end
                MOVING: begin
                    if ((i_present_floor == r_req_floor) || (|(r_pending & i_present_floor))) begin
                        w_state_nxt = DOOR;
                        w_clr       = i_present_floor;
                        w_dwell_nxt = DWELL_LOAD;
                        w_door_nxt  = 1'b1;
                        w_req_nxt   = i_present_floor;
                    end else if (r_dir_up && (|w_pend_above)) begin
                        w_req_nxt   = lowestBit(w_pend_above);
                    end else if (!r_dir_up && (|w_pend_below)) begin
                        w_req_nxt   = highestBit(w_pend_below);
                    end else if (|w_pend_above) begin
                        w_dir_nxt   = 1'b1;
                        w_req_nxt   = lowestBit(w_pend_above);
                    end else if (|w_pend_below) begin
                        w_dir_nxt   = 1'b0;
                        w_req_nxt   = highestBit(w_pend_below);
                    end else begin
                        w_state_nxt = IDLE;
                        w_req_nxt   = i_present_floor;
                    end
                end
                DOOR: begin
                    w_req_nxt = i_present_floor;
                    // A call at the open floor keeps the door open instead of queueing a revisit.
                    if (w_here_call) begin
                        w_clr       = i_present_floor;
                        w_dwell_nxt = DWELL_LOAD;
                    end else if (i_tick) begin
                        if (r_dwell <= 4'd1) begin
                            w_state_nxt = IDLE;
                            w_door_nxt  = 1'b0;
                            w_dwell_nxt = 4'd0;
                        end else begin
                            w_dwell_nxt = r_dwell - 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_pending_nxt = (r_pending | i_call_btn) & ~w_clr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_req_floor <= 4'b0001;
            r_pending   <= 4'd0;
            r_dwell     <= 4'd0;
            r_door_open <= 1'b0;
            r_dir_up    <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_floor <= w_req_nxt;
            r_pending   <= w_pending_nxt;
            r_dwell     <= w_dwell_nxt;
            r_door_open <= w_door_nxt;
            r_dir_up    <= w_dir_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign o_req_floor = r_req_floor;
    assign o_pending   = r_pending;
    assign o_door_open = r_door_open;
    assign o_dir_up    = r_dir_up;
    assign o_busy      = r_busy;

endmodule
